// File: rtl/tick_timer_if.sv
// Control/status bundle for tick_timer: the master drives the controls, the
// timer (slave) drives the tick/done pulses and the status flags.
interface tick_timer_if #(
    parameter int TICKS_W = 8
);
    logic               run;
    logic               clear;
    logic               mode;
    logic [TICKS_W-1:0] limit;
    logic               tick;
    logic               done;
    logic [TICKS_W-1:0] ticks;
    logic               busy;
    logic               expired;

    modport master (
        output run, clear, mode, limit,
        input  tick, done, ticks, busy, expired
    );

    modport slave (
        input  run, clear, mode, limit,
        output tick, done, ticks, busy, expired
    );
endinterface

// File: rtl/tick_timer.sv
// Prescaled tick timer with periodic/one-shot expiry and synchronous clear.
// Define TICK_TIMER_PAUSE_EN to make run=0 pause the count instead of aborting it.
module tick_timer #(
    parameter int CYCLES_PER_TICK = 50000000,
    parameter int TICKS_W         = 8
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    tick_timer_if.slave  bus
);
    localparam int PC_W = $clog2(CYCLES_PER_TICK);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(CYCLES_PER_TICK - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [TICKS_W-1:0] ticks_q;
    logic [TICKS_W-1:0] limit_q;
    logic [TICKS_W-1:0] ticks_inc;
    logic               mode_q;
    logic               tick_q;
    logic               done_q;
    logic               busy_q;
    logic               expired_q;

    assign ticks_inc = ticks_q + TICKS_W'(1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            ticks_q   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                pc        <= '0;
                ticks_q   <= '0;
                busy_q    <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.run) begin
                            state   <= RUN;
                            pc      <= '0;
                            ticks_q <= '0;
                            limit_q <= bus.limit;
                            mode_q  <= bus.mode;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!bus.run) begin
                            busy_q <= 1'b0;
`ifdef TICK_TIMER_PAUSE_EN
                            state  <= PAUSE;
`else
                            state   <= IDLE;
                            pc      <= '0;
                            ticks_q <= '0;
`endif
                        end else if (pc == PC_LAST) begin
                            pc     <= '0;
                            tick_q <= 1'b1;
                            // A zero limit never matches, so the count simply wraps.
                            if (limit_q != '0 && ticks_inc == limit_q) begin
                                done_q <= 1'b1;
                                if (mode_q) begin
                                    ticks_q   <= ticks_inc;
                                    state     <= DONE;
                                    busy_q    <= 1'b0;
                                    expired_q <= 1'b1;
                                end else begin
                                    ticks_q <= '0;
                                end
                            end else begin
                                ticks_q <= ticks_inc;
                            end
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                    PAUSE: begin
`ifdef TICK_TIMER_PAUSE_EN
                        if (bus.run) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
`else
                        state   <= IDLE;
                        pc      <= '0;
                        ticks_q <= '0;
`endif
                    end
                    DONE: begin
                        // Holding run high keeps the result visible; a fresh start needs run low first.
                        if (!bus.run) begin
                            state     <= IDLE;
                            pc        <= '0;
                            ticks_q   <= '0;
                            expired_q <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        pc        <= '0;
                        ticks_q   <= '0;
                        busy_q    <= 1'b0;
                        expired_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.ticks   = ticks_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus randomized
// stimulus compared against an elapsed-cycle reference model.
`timescale 1ns/1ps
module tb_tick_timer;
    localparam int CPT = 4;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    tick_timer_if #(.TICKS_W(TW)) bus ();

    tick_timer #(.CYCLES_PER_TICK(CPT), .TICKS_W(TW)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 counting, 2 paused, 3 expired.
    // Everything else follows from the number of counted cycles since start.
    int ph = 0;
    int cnt = 0;
    int lat_lim = 0;
    bit lat_mode = 1'b0;
    bit m_tick = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph = 0; cnt = 0; lat_lim = 0; lat_mode = 1'b0; m_tick = 1'b0; m_done = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_done = 1'b0;
            if (bus.clear) begin
                ph = 0; cnt = 0;
            end else begin
                case (ph)
                    0: if (bus.run) begin
                        ph = 1; cnt = 0; lat_lim = int'(bus.limit); lat_mode = bus.mode;
                    end
                    1: if (!bus.run) begin
`ifdef TICK_TIMER_PAUSE_EN
                        ph = 2;
`else
                        ph = 0; cnt = 0;
`endif
                    end else begin
                        cnt++;
                        if (cnt % CPT == 0) begin
                            m_tick = 1'b1;
                            if (lat_lim != 0 && (cnt / CPT) % lat_lim == 0) begin
                                m_done = 1'b1;
                                if (lat_mode) ph = 3;
                            end
                        end
                    end
                    2: if (bus.run) ph = 1;
                    3: if (!bus.run) begin ph = 0; cnt = 0; end
                    default: ph = 0;
                endcase
            end
        end
    end

    function automatic int exp_ticks();
        int n;
        if (ph == 0) return 0;
        if (ph == 3) return lat_lim;
        n = cnt / CPT;
        return (lat_lim != 0) ? n % lat_lim : n % (1 << TW);
    endfunction

    // Packed {tick, done, busy, expired, ticks}
    function automatic logic [TW+3:0] vec(input logic t, input logic d, input logic b,
                                          input logic e, input int n);
        return {t, d, b, e, TW'(n)};
    endfunction

    function automatic logic [TW+3:0] got();
        return {bus.tick, bus.done, bus.busy, bus.expired, bus.ticks};
    endfunction

    task automatic go_idle();
        @(negedge clk);
        bus.run = 1'b0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [TW+3:0] g;
        bus.run = 1'b1; bus.clear = 1'b0; bus.mode = 1'b0; bus.limit = '0;
        reset_n = 1'b0;
        #1;
        g = got();
        checks++;
        if (g !== vec(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", g, vec(0, 0, 0, 0, 0));
        end
        repeat (3) @(negedge clk);
        g = got();
        checks++;
        if (g !== vec(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", g, vec(0, 0, 0, 0, 0));
        end
        bus.run = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_periodic();
        logic [TW+3:0] g, e;
        go_idle();
        bus.mode = 1'b0; bus.limit = TW'(3); bus.run = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            g = got();
            e = vec(k % 4 == 0, k == 12, 1, 0, (k / 4) % 3);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL periodic edge=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [TW+3:0] g, e;
        go_idle();
        bus.mode = 1'b1; bus.limit = TW'(2); bus.run = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 9) bus.limit = TW'(5);
            @(negedge clk);
            g = got();
            e = (k <= 8) ? vec(k % 4 == 0, k == 8, k < 8, k == 8, k / 4) : vec(0, 0, 0, 1, 2);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL oneshot edge=%0d got=%h exp=%h", k, g, e);
            end
        end
        bus.run = 1'b0;
        @(negedge clk);
        g = got();
        checks++;
        if (g !== vec(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL oneshot_to_idle got=%h exp=%h", g, vec(0, 0, 0, 0, 0));
        end
        bus.limit = TW'(2); bus.run = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            g = got();
            e = vec(k == 4, 0, 1, 0, (k == 4) ? 1 : 0);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL oneshot_restart edge=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [TW+3:0] g, e;
        go_idle();
        bus.mode = 1'b0; bus.limit = '0; bus.run = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            g = got();
            e = vec(k % 4 == 0, 0, 1, 0, (k / 4) % 16);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL wrap edge=%0d got=%h exp=%h", k, g, e);
            end
            if (k == 30) begin
                bus.limit = TW'(1); bus.mode = 1'b1;
            end
        end
    endtask

    task automatic test_clear();
        logic [TW+3:0] g;
        go_idle();
        bus.mode = 1'b0; bus.limit = '0; bus.run = 1'b1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        g = got();
        checks++;
        if (g !== vec(0, 0, 1, 0, 1)) begin
            failures++;
            $display("FAIL clear_setup got=%h exp=%h", g, vec(0, 0, 1, 0, 1));
        end
        bus.clear = 1'b1;
        @(negedge clk);
        g = got();
        checks++;
        if (g !== vec(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL clear_abort got=%h exp=%h", g, vec(0, 0, 0, 0, 0));
        end
        bus.clear = 1'b0;
        @(negedge clk);
        g = got();
        checks++;
        if (g !== vec(0, 0, 1, 0, 0)) begin
            failures++;
            $display("FAIL clear_rerun got=%h exp=%h", g, vec(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_pause();
        logic [TW+3:0] g, e;
        int held;
`ifdef TICK_TIMER_PAUSE_EN
        held = 1;
`else
        held = 0;
`endif
        go_idle();
        bus.mode = 1'b0; bus.limit = '0; bus.run = 1'b1;
        @(negedge clk);
        repeat (6) @(negedge clk);
        bus.run = 1'b0;
        for (int k = 7; k <= 11; k++) begin
            @(negedge clk);
            g = got();
            e = vec(0, 0, 0, 0, held);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL pause_hold edge=%0d got=%h exp=%h", k, g, e);
            end
        end
        bus.run = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            g = got();
            if (held == 1) e = vec(k == 2, 0, 1, 0, (k >= 2) ? 2 : 1);
            else           e = vec(k == 4, 0, 1, 0, (k == 4) ? 1 : 0);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL pause_resume edge=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [TW+3:0] g, e;
        go_idle();
        bus.mode = 1'b0; bus.limit = '0; bus.run = 1'b1;
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        g = got();
        checks++;
        if (g !== vec(0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", g, vec(0, 0, 0, 0, 0));
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            g = got();
            e = vec(k == 4, 0, 1, 0, (k == 4) ? 1 : 0);
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL async_restart edge=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_random();
        logic [TW+3:0] g, e;
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g = got();
            e = vec(m_tick, m_done, ph == 1, ph == 3, exp_ticks());
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h exp=%h", i, g, e);
            end
            if (i == 1500) reset_n = 1'b0;
            else           reset_n = 1'b1;
            if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
            bus.clear = ($urandom_range(0, 63) == 0);
            bus.mode  = 1'($urandom_range(0, 1));
            bus.limit = TW'($urandom_range(0, 4));
        end
        reset_n = 1'b1;
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0; bus.clear = 1'b0; bus.mode = 1'b0; bus.limit = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_wrap();
        test_clear();
        test_pause();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
